mix_columns_iter: RTL and testbench

MIX_COLUMNS_ITER -- requirements
Module: mix_columns_iter

---
 rtl/mix_columns_iter.sv | 115 +++++++++++
 tb/tb_mix_columns_iter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns: one group of COLS_PER_CYCLE columns
// is transformed in place per clock, with valid/ready handshakes on both sides.

module mix_columns_lane (
    input  logic [31:0] col_i,
    input  logic        inv_i,
    output logic [31:0] col_o
);
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a [4];
    logic [7:0] p [4];
    logic [7:0] u, v, t;

    always_comb begin
        for (int r = 0; r < 4; r++) a[r] = col_i[31-8*r -: 8];
        u = xtime(xtime(a[0] ^ a[2]));
        v = xtime(xtime(a[1] ^ a[3]));
        // Inverse = preconditioning step followed by the forward transform.
        p[0] = inv_i ? a[0] ^ u : a[0];
        p[1] = inv_i ? a[1] ^ v : a[1];
        p[2] = inv_i ? a[2] ^ u : a[2];
        p[3] = inv_i ? a[3] ^ v : a[3];
        t = p[0] ^ p[1] ^ p[2] ^ p[3];
        col_o = '0;
        for (int r = 0; r < 4; r++)
            col_o[31-8*r -: 8] = p[r] ^ t ^ xtime(p[r] ^ p[(r+1)%4]);
    end
endmodule

module mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit INV_EN         = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         inv_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [1:0] LAST_GRP = 2'(4 / COLS_PER_CYCLE - 1);

    state_t             state_q, state_d;
    logic [1:0]         col_cnt_q, col_cnt_d;
    logic [3:0][31:0]   work_q, work_d;
    logic               inv_q, inv_d;

    logic [COLS_PER_CYCLE-1:0][1:0]  col_idx;
    logic [COLS_PER_CYCLE-1:0][31:0] lane_out;

    // Column c lives in packed slot 3-c (column 0 is the MSW), i.e. slot ~c.
    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
        assign col_idx[k] = 2'(int'(col_cnt_q) * COLS_PER_CYCLE + k);
        mix_columns_lane u_lane (
            .col_i (work_q[~col_idx[k]]),
            .inv_i (inv_q),
            .col_o (lane_out[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            col_cnt_q <= 2'd0;
            work_q    <= '0;
            inv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            work_q    <= work_d;
            inv_q     <= inv_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        work_d    = work_q;
        inv_d     = inv_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            BUSY: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++)
                    work_d[~col_idx[k]] = lane_out[k];
                col_cnt_d = col_cnt_q + 2'd1;
                if (col_cnt_q == LAST_GRP) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Capture overrides the DONE->IDLE exit so blocks can stream back to back.
        if (in_valid && in_ready) begin
            work_d    = state_in;
            inv_d     = inv_in & INV_EN;
            col_cnt_d = 2'd0;
            state_d   = BUSY;
        end
    end

    assign state_o = work_q;
endmodule

// File: tb/tb_mix_columns_iter.sv
// Directed and round-trip checks of mix_columns_iter for 1, 2 and 4 columns per cycle.

module tb_mix_columns_iter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] state_in  [3];
    logic         inv_in    [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] state_o   [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mix_columns_iter #(.COLS_PER_CYCLE(1)) u_n1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .state_in(state_in[0]), .inv_in(inv_in[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .state_o(state_o[0]));
    mix_columns_iter #(.COLS_PER_CYCLE(2)) u_n2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .state_in(state_in[1]), .inv_in(inv_in[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .state_o(state_o[1]));
    mix_columns_iter #(.COLS_PER_CYCLE(4)) u_n4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .state_in(state_in[2]), .inv_in(inv_in[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .state_o(state_o[2]));

    typedef struct {
        int           dut;   // 0: N=1, 1: N=2, 2: N=4
        logic         inv;
        logic [127:0] din;
        logic [127:0] dout;
        int           lat;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic launch(input int i, input logic inv, input logic [127:0] din);
        @(negedge clk);
        in_valid[i] = 1'b1;
        inv_in[i]   = inv;
        state_in[i] = din;
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
    endtask

    // Cycles counted from the accepting edge; -1 if out_valid never rises.
    task automatic wait_out(input int i, output logic [127:0] dout, output int cyc);
        cyc  = -1;
        dout = 'x;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (out_valid[i]) begin
                cyc  = c;
                dout = state_o[i];
                break;
            end
        end
    endtask

    task automatic run_blk(input int i, input logic inv, input logic [127:0] din,
                           output logic [127:0] dout, output int cyc);
        launch(i, inv, din);
        wait_out(i, dout, cyc);
    endtask

    initial begin
        logic [127:0] res, mid, rnd;
        int           cyc, cyc2;
        logic         seen;

        vecs[0] = '{0, 1'b0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 4};
        vecs[1] = '{2, 1'b1, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1};
        vecs[2] = '{1, 1'b0, 128'hd4d4d4d5_2d26314c_00000000_ffffffff, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, 2};
        vecs[3] = '{0, 1'b1, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 4};
        vecs[4] = '{1, 1'b1, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, 128'hd4d4d4d5_2d26314c_00000000_ffffffff, 2};
        vecs[5] = '{2, 1'b0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1};
        vecs[6] = '{1, 1'b0, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 128'h046681e5_e0cb199a_48f8d37a_2806264c, 2};
        vecs[7] = '{0, 1'b1, 128'h046681e5_e0cb199a_48f8d37a_2806264c, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 4};
        vecs[8] = '{2, 1'b0, 128'h0, 128'h0, 1};
        vecs[9] = '{0, 1'b0, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 128'h046681e5_e0cb199a_48f8d37a_2806264c, 4};

        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0; inv_in[i] = 1'b0; state_in[i] = '0; out_ready[i] = 1'b1;
        end

        // Reset state
        #7;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_in_ready[%0d]", i), 128'(in_ready[i]), 128'd1);
            chk($sformatf("rst_out_valid[%0d]", i), 128'(out_valid[i]), 128'd0);
            chk($sformatf("rst_state_o[%0d]", i), state_o[i], 128'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        for (int v = 0; v < 10; v++) begin
            run_blk(vecs[v].dut, vecs[v].inv, vecs[v].din, res, cyc);
            chk($sformatf("vec%0d_latency", v), 128'(cyc), 128'(vecs[v].lat));
            chk($sformatf("vec%0d_state", v), res, vecs[v].dout);
        end
        repeat (2) @(posedge clk);

        // Backpressure hold, then back-to-back capture out of DONE (N=1)
        out_ready[0] = 1'b0;
        run_blk(0, 1'b0, vecs[0].din, res, cyc);
        chk("hold_first_latency", 128'(cyc), 128'd4);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d", c), {out_valid[0], in_ready[0], state_o[0]},
                {1'b1, 1'b0, vecs[0].dout});
        end
        @(negedge clk);
        in_valid[0] = 1'b1; inv_in[0] = 1'b0; state_in[0] = vecs[6].din; out_ready[0] = 1'b1;
        #1;
        chk("b2b_in_ready", 128'(in_ready[0]), 128'd1);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        chk("b2b_busy_out_valid", 128'(out_valid[0]), 128'd0);
        chk("b2b_busy_in_ready", 128'(in_ready[0]), 128'd0);
        wait_out(0, res, cyc);
        chk("b2b_latency", 128'(cyc), 128'd4);
        chk("b2b_state", res, vecs[6].dout);

        // in_valid held during BUSY must not re-capture (N=1)
        launch(0, 1'b0, vecs[2].din);
        @(negedge clk);
        in_valid[0] = 1'b1; state_in[0] = 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef;
        wait_out(0, res, cyc);
        in_valid[0] = 1'b0;
        chk("busy_ignore_latency", 128'(cyc), 128'd4);
        chk("busy_ignore_state", res, vecs[2].dout);
        repeat (2) @(posedge clk);

        // Async reset mid-BUSY (N=1)
        launch(0, 1'b0, vecs[0].din);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 128'(out_valid[0]), 128'd0);
        chk("mid_rst_in_ready", 128'(in_ready[0]), 128'd1);
        chk("mid_rst_state_o", state_o[0], 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid[0]) seen = 1'b1;
        end
        chk("post_rst_no_out_valid", 128'(seen), 128'd0);
        run_blk(0, 1'b0, vecs[2].din, res, cyc);
        chk("post_rst_latency", 128'(cyc), 128'd4);
        chk("post_rst_state", res, vecs[2].dout);

        // Random forward-then-inverse round trips
        for (int i = 0; i < 3; i++) begin
            for (int b = 0; b < 1000; b++) begin
                rnd = {$urandom, $urandom, $urandom, $urandom};
                run_blk(i, 1'b0, rnd, mid, cyc);
                run_blk(i, 1'b1, mid, res, cyc2);
                chk($sformatf("roundtrip_n%0d_b%0d", i, b),
                    {res, 8'(cyc), 8'(cyc2)}, {rnd, 8'(4 >> i), 8'(4 >> i)});
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
